// File: rtl/dna_word_serializer.sv
// rtl/dna_word_serializer.sv - decodes complemented DNA words and streams bases one per cycle (option: DNA_MSB_FIRST_EN)
module dna_word_serializer #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2*N-1:0]   word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [1:0]       base_out,
    output logic             base_valid,
    input  logic             base_ready,
    output logic             base_last
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_SEQ = IW'(N - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t           r_state;
    logic [2*N-1:0]   r_word;
    logic [IW-1:0]    r_idx;

    logic [2*N-1:0]   w_decoded;
    logic [IW-1:0]    w_idx_next;
    logic             w_take;
    logic             w_final;
    logic             w_accept;

    // Map an emission slot (0 = first digit sent) to the digit it carries.
    function automatic logic [1:0] pick(input logic [2*N-1:0] w, input logic [IW-1:0] seq);
        int          pos;
        logic [1:0]  d;
`ifdef DNA_MSB_FIRST_EN
        pos = N - 1 - int'(seq);
`else
        pos = int'(seq);
`endif
        d = 2'b00;
        for (int i = 0; i < N; i++) begin
            if (i == pos) begin
                d = w[2*i +: 2];
            end
        end
        return d;
    endfunction

    // Complement decode is its own inverse: flipping the low bit of each digit.
    always_comb begin
        w_decoded = '0;
        for (int i = 0; i < N; i++) begin
            w_decoded[2*i +: 2] = {word_in[2*i+1], ~word_in[2*i]};
        end
    end

    assign w_take     = base_valid & base_ready;
    assign w_final    = w_take & base_last;
    assign w_idx_next = r_idx + IW'(1);
    assign word_ready = !rst & ((r_state == IDLE) | w_final);
    assign w_accept   = word_valid & word_ready;

    // Word capture, digit sequencing and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_word     <= '0;
            r_idx      <= '0;
            base_out   <= 2'b00;
            base_valid <= 1'b0;
            base_last  <= 1'b0;
        end else if (w_accept) begin
            r_state    <= SEND;
            r_word     <= w_decoded;
            r_idx      <= '0;
            base_out   <= pick(w_decoded, IW'(0));
            base_valid <= 1'b1;
            base_last  <= (LAST_SEQ == IW'(0));
        end else if (w_take) begin
            if (base_last) begin
                r_state    <= IDLE;
                r_idx      <= '0;
                base_valid <= 1'b0;
                base_last  <= 1'b0;
            end else begin
                r_idx      <= w_idx_next;
                base_out   <= pick(r_word, w_idx_next);
                base_last  <= (w_idx_next == LAST_SEQ);
            end
        end
    end

endmodule

// File: tb/tb_dna_word_serializer.sv
// tb/tb_dna_word_serializer.sv - scoreboard bench for dna_word_serializer
module tb_dna_word_serializer;

    localparam int N = 4;

    logic            clk;
    logic            rst;
    logic [2*N-1:0]  word_in;
    logic            word_valid;
    logic            word_ready;
    logic [1:0]      base_out;
    logic            base_valid;
    logic            base_ready;
    logic            base_last;

    typedef struct {
        logic [1:0] b;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    logic accepted;
    logic rst_prev;
    logic [1:0] comp_tab [4];

    dna_word_serializer #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .base_out   (base_out),
        .base_valid (base_valid),
        .base_ready (base_ready),
        .base_last  (base_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: complement table lookup, emission order from the build option.
    task automatic push_word(input logic [2*N-1:0] w);
        exp_t e;
        int   pos;
        logic [1:0] d;
        for (int k = 0; k < N; k++) begin
`ifdef DNA_MSB_FIRST_EN
            pos = N - 1 - k;
`else
            pos = k;
`endif
            d      = w[2*pos +: 2];
            e.b    = comp_tab[d];
            e.last = (k == N - 1);
            exp_q.push_back(e);
        end
    endtask

    // Stimulus-side expectation: handshake-level rules, accept capture, reset flush.
    always @(negedge clk) begin
        if (rst) begin
            chk("ready_in_reset", {7'b0, word_ready}, 8'd0);
            if (rst_prev) begin
                chk("rst_base_valid", {7'b0, base_valid}, 8'd0);
                chk("rst_base_out", {6'b0, base_out}, 8'd0);
                chk("rst_base_last", {7'b0, base_last}, 8'd0);
            end
            exp_q.delete();
        end else begin
            chk("base_valid", {7'b0, base_valid}, {7'b0, exp_q.size() > 0});
            chk("word_ready", {7'b0, word_ready},
                {7'b0, (exp_q.size() == 0) || (exp_q.size() == 1 && base_ready)});
            if (word_valid && word_ready) begin
                push_word(word_in);
                accepted = 1'b1;
            end
        end
        rst_prev = rst;
    end

    // Monitor: every presented digit must match the head of the scoreboard.
    always begin
        @(negedge clk);
        #1;
        if (!rst && base_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_base: got %0b with empty scoreboard at %0t", base_out, $time);
            end else begin
                chk("base_out", {6'b0, base_out}, {6'b0, exp_q[0].b});
                chk("base_last", {7'b0, base_last}, {7'b0, exp_q[0].last});
                if (base_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [2*N-1:0] w);
        int n;
        word_in    = w;
        word_valid = 1'b1;
        accepted   = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!accepted && n < 200);
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %0h not accepted, required accept", w);
        end
        @(posedge clk);
        #1;
        accepted = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_random(input int cycles, input int pv, input int pr);
        for (int c = 0; c < cycles; c++) begin
            if (accepted || !word_valid) begin
                accepted   = 1'b0;
                word_valid = ($urandom_range(99) < pv);
                word_in    = 2*N'($urandom);
            end
            base_ready = ($urandom_range(99) < pr);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        comp_tab[0] = 2'b01;
        comp_tab[1] = 2'b00;
        comp_tab[2] = 2'b11;
        comp_tab[3] = 2'b10;
        checks     = 0;
        errors     = 0;
        accepted   = 1'b0;
        rst_prev   = 1'b0;
        rst        = 1'b1;
        word_valid = 1'b1;
        word_in    = 8'hA5;
        base_ready = 1'b0;
        idle(4);

        // Release with a word waiting: must be accepted in the release cycle.
        rst        = 1'b0;
        base_ready = 1'b1;
        send_word(8'b00_01_10_11);
        word_valid = 1'b0;
        idle(6);

        // Backpressure at the second digit.
        send_word(8'b00_01_10_11);
        word_valid = 1'b0;
        idle(1);
        base_ready = 1'b0;
        idle(3);
        base_ready = 1'b1;
        idle(6);

        // Back-to-back words with ready held high.
        send_word(8'hFF);
        send_word(8'h00);
        send_word(8'h1B);
        word_valid = 1'b0;
        idle(8);

        // Reset during a word in flight.
        send_word(8'b00_01_10_11);
        word_valid = 1'b0;
        idle(1);
        rst        = 1'b1;
        base_ready = 1'b0;
        idle(2);
        rst        = 1'b0;
        base_ready = 1'b1;
        idle(4);
        send_word(8'h6C);
        word_valid = 1'b0;
        idle(6);

        // Randomized traffic with varying valid/ready densities.
        run_random(400, 70, 60);
        run_random(400, 100, 100);
        run_random(400, 40, 30);
        rst        = 1'b1;
        word_valid = 1'b0;
        base_ready = 1'b0;
        idle(2);
        rst = 1'b0;
        run_random(300, 80, 75);

        // Drain.
        word_valid = 1'b0;
        base_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            idle(1);
            n++;
        end
        idle(2);
        chk("drain_empty", 8'(exp_q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
